// File: rtl/rect_pos_ctl_if.sv
// Move-request handshake between a position source and rect_pos_ctl.
// The master drives a target corner and jump flag; the slave answers with ready.
interface rect_pos_ctl_if;
  logic        req_valid;
  logic [11:0] req_x;
  logic [11:0] req_y;
  logic        req_jump;
  logic        req_ready;

  modport master (output req_valid, req_x, req_y, req_jump, input req_ready);
  modport slave  (input req_valid, req_x, req_y, req_jump, output req_ready);
endinterface

// File: rtl/rect_pos_ctl.sv
// Frame-synchronous rectangle position controller: accepts move requests and
// jumps or glides the on-screen rectangle toward the clamped target, one step per frame.
module rect_pos_ctl #(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_ACTIVE    = 600,
  parameter int unsigned RECT_WIDTH  = 48,
  parameter int unsigned RECT_HEIGHT = 64,
  parameter int unsigned STEP        = 4,
  parameter int unsigned INIT_X      = 0,
  parameter int unsigned INIT_Y      = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vblnk,
  rect_pos_ctl_if.slave req,
  output logic [11:0]   x_pos,
  output logic [11:0]   y_pos,
  output logic          busy,
  output logic          done
);

  localparam int unsigned POS_W = 12;

  localparam logic [POS_W-1:0] MAX_X  = POS_W'(H_ACTIVE - RECT_WIDTH);
  localparam logic [POS_W-1:0] MAX_Y  = POS_W'(V_ACTIVE - RECT_HEIGHT);
  localparam logic [POS_W-1:0] STEP_W = POS_W'(STEP);
  localparam logic [POS_W-1:0] INIT_XW = POS_W'(INIT_X);
  localparam logic [POS_W-1:0] INIT_YW = POS_W'(INIT_Y);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    GLIDE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [POS_W-1:0] tgt_x, tgt_y, tgt_x_nxt, tgt_y_nxt;
  logic [POS_W-1:0] x_nxt, y_nxt, step_x, step_y, clamp_x, clamp_y;
  logic             mode, mode_nxt;
  logic             vblnk_d;
  logic             busy_nxt, done_nxt;
  logic             frame_start, accept;

  // One glide step on a single axis; lands exactly on the target when within STEP.
  function automatic logic [POS_W-1:0] step_axis(input logic [POS_W-1:0] pos,
                                                 input logic [POS_W-1:0] tgt);
    logic [POS_W-1:0] res;
    if (tgt >= pos) begin
      res = ((tgt - pos) <= STEP_W) ? tgt : pos + STEP_W;
    end else begin
      res = ((pos - tgt) <= STEP_W) ? tgt : pos - STEP_W;
    end
    return res;
  endfunction

  assign frame_start   = vblnk & ~vblnk_d;
  assign req.req_ready = (state != ARMED);
  assign accept        = req.req_valid & req.req_ready;
  assign clamp_x       = (req.req_x > MAX_X) ? MAX_X : req.req_x;
  assign clamp_y       = (req.req_y > MAX_Y) ? MAX_Y : req.req_y;
  assign step_x        = step_axis(x_pos, tgt_x);
  assign step_y        = step_axis(y_pos, tgt_y);

  // Next-state and next-output decode.
  always_comb begin
    state_nxt = state;
    x_nxt     = x_pos;
    y_nxt     = y_pos;
    tgt_x_nxt = tgt_x;
    tgt_y_nxt = tgt_y;
    mode_nxt  = mode;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          tgt_x_nxt = clamp_x;
          tgt_y_nxt = clamp_y;
          mode_nxt  = req.req_jump;
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (frame_start) begin
          if (mode) begin
            x_nxt     = tgt_x;
            y_nxt     = tgt_y;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            x_nxt = step_x;
            y_nxt = step_y;
            if ((step_x == tgt_x) && (step_y == tgt_y)) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = GLIDE;
            end
          end
        end
      end
      GLIDE: begin
        // A new request takes priority over a coincident frame step.
        if (accept) begin
          tgt_x_nxt = clamp_x;
          tgt_y_nxt = clamp_y;
          mode_nxt  = req.req_jump;
          state_nxt = ARMED;
        end else if (frame_start) begin
          x_nxt = step_x;
          y_nxt = step_y;
          if ((step_x == tgt_x) && (step_y == tgt_y)) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x_pos   <= INIT_XW;
      y_pos   <= INIT_YW;
      tgt_x   <= INIT_XW;
      tgt_y   <= INIT_YW;
      mode    <= 1'b0;
      vblnk_d <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      x_pos   <= x_nxt;
      y_pos   <= y_nxt;
      tgt_x   <= tgt_x_nxt;
      tgt_y   <= tgt_y_nxt;
      mode    <= mode_nxt;
      vblnk_d <= vblnk;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_rect_pos_ctl.sv
// Self-checking bench for rect_pos_ctl: directed vector table, hand-written
// retarget/reset sequences, then random traffic against a behavioural model.
module tb_rect_pos_ctl;

  localparam int STEP  = 4;
  localparam int MAX_X = 800 - 48;
  localparam int MAX_Y = 600 - 64;

  logic        clk;
  logic        rst_n;
  logic        vblnk;
  logic [11:0] x_pos, y_pos;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;

  rect_pos_ctl_if bus ();

  rect_pos_ctl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vblnk (vblnk),
    .req   (bus),
    .x_pos (x_pos),
    .y_pos (y_pos),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: position, target, and whether a request awaits its first frame.
  int m_x, m_y, m_tx, m_ty;
  bit m_jump, m_wait, m_move, m_done, m_vd;

  function automatic int clampi(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  function automatic int glide(input int pos, input int tgt);
    int d;
    d = tgt - pos;
    if (d <= STEP && d >= -STEP) return tgt;
    return (d > 0) ? pos + STEP : pos - STEP;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_tx = 0; m_ty = 0;
    m_jump = 0; m_wait = 0; m_move = 0; m_done = 0; m_vd = 1;
  endtask

  task automatic model_step(input bit vb, input bit v, input int x, input int y, input bit j);
    bit fs, acc;
    fs   = vb && !m_vd;
    m_vd = vb;
    acc  = v && !m_wait;
    m_done = 0;
    if (acc) begin
      m_tx = clampi(x & 4095, MAX_X);
      m_ty = clampi(y & 4095, MAX_Y);
      m_jump = j; m_wait = 1; m_move = 0;
    end else if (fs && (m_wait || m_move)) begin
      if (m_wait && m_jump) begin
        m_x = m_tx; m_y = m_ty;
      end else begin
        m_x = glide(m_x, m_tx); m_y = glide(m_y, m_ty);
      end
      m_wait = 0;
      if (m_x == m_tx && m_y == m_ty) begin
        m_done = 1; m_move = 0;
      end else begin
        m_move = 1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".x_pos"}, int'(x_pos), m_x);
    chk({tag, ".y_pos"}, int'(y_pos), m_y);
    chk({tag, ".busy"}, int'(busy), int'(m_wait || m_move));
    chk({tag, ".done"}, int'(done), int'(m_done));
    chk({tag, ".ready"}, int'(bus.req_ready), int'(!m_wait));
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, wait one cycle.
  task automatic apply(input bit vb, input bit v, input int x, input int y, input bit j);
    vblnk         = vb;
    bus.req_valid = v;
    bus.req_x     = 12'(x);
    bus.req_y     = 12'(y);
    bus.req_jump  = j;
    model_step(vb, v, x, y, j);
    @(negedge clk);
  endtask

  typedef struct {
    bit vb; bit v; int x; int y; bit j;
    int ex; int ey; bit eb; bit ed; bit er;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // glide (0,0)->(10,3), then jump, handshake hold, clamp and same-target cases
    tbl[0]  = '{0, 1, 10, 3, 0,     0,   0,   1, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0,      4,   3,   1, 0, 1};
    tbl[2]  = '{0, 0, 0, 0, 0,      4,   3,   1, 0, 1};
    tbl[3]  = '{1, 0, 0, 0, 0,      8,   3,   1, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 0,      8,   3,   1, 0, 1};
    tbl[5]  = '{1, 0, 0, 0, 0,      10,  3,   0, 1, 1};
    tbl[6]  = '{0, 0, 0, 0, 0,      10,  3,   0, 0, 1};
    tbl[7]  = '{0, 1, 300, 200, 1,  10,  3,   1, 0, 0};
    tbl[8]  = '{0, 1, 5, 5, 0,      10,  3,   1, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 0,      300, 200, 0, 1, 1};
    tbl[10] = '{0, 1, 900, 700, 1,  300, 200, 1, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 0,      752, 536, 0, 1, 1};
    tbl[12] = '{0, 1, 4095, 4095, 1, 752, 536, 1, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 0,      752, 536, 0, 1, 1};
    tbl[14] = '{0, 0, 0, 0, 0,      752, 536, 0, 0, 1};

    rst_n = 1'b0; vblnk = 1'b0;
    bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0; bus.req_jump = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.x_pos", int'(x_pos), 0);
    chk("rst.y_pos", int'(y_pos), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.ready", int'(bus.req_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].vb, tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].j);
      chk($sformatf("vec%0d.x_pos", i), int'(x_pos), tbl[i].ex);
      chk($sformatf("vec%0d.y_pos", i), int'(y_pos), tbl[i].ey);
      chk($sformatf("vec%0d.busy", i), int'(busy), int'(tbl[i].eb));
      chk($sformatf("vec%0d.done", i), int'(done), int'(tbl[i].ed));
      chk($sformatf("vec%0d.ready", i), int'(bus.req_ready), int'(tbl[i].er));
    end

    // Retarget: at (40,0) gliding to (100,0), new target (20,0) accepted on a frame edge
    apply(0, 1, 36, 0, 1);
    apply(1, 0, 0, 0, 0);
    chk("rt.jump_x", int'(x_pos), 36);
    apply(0, 1, 100, 0, 0);
    apply(1, 0, 0, 0, 0);
    chk("rt.first_x", int'(x_pos), 40);
    chk("rt.glide_busy", int'(busy), 1);
    apply(0, 0, 0, 0, 0);
    apply(1, 1, 20, 0, 0);
    chk("rt.hold_x", int'(x_pos), 40);
    chk("rt.hold_ready", int'(bus.req_ready), 0);
    for (int k = 1; k <= 5; k++) begin
      apply(0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0);
      chk($sformatf("rt.step%0d_x", k), int'(x_pos), 40 - 4 * k);
      chk($sformatf("rt.step%0d_done", k), int'(done), (k == 5) ? 1 : 0);
    end
    chk_model("rt");

    // Asynchronous reset mid-glide, then release with vblnk already high
    apply(0, 1, 400, 300, 0);
    apply(1, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0);
    chk("ar.pre_busy", int'(busy), 1);
    vblnk = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("ar.x_pos", int'(x_pos), 0);
    chk("ar.y_pos", int'(y_pos), 0);
    chk("ar.busy", int'(busy), 0);
    chk("ar.ready", int'(bus.req_ready), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 1, 100, 100, 0);
    chk("ar.armed_ready", int'(bus.req_ready), 0);
    apply(1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0);
    chk("ar.no_move_x", int'(x_pos), 0);
    chk("ar.still_busy", int'(busy), 1);
    apply(0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0);
    chk("ar.move_x", int'(x_pos), 4);
    chk("ar.move_y", int'(y_pos), 4);
    chk_model("ar");

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit vb, v, j;
      int x, y;
      vb = ($urandom_range(0, 2) == 0);
      v  = ($urandom_range(0, 19) == 0);
      j  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin
        x = int'($urandom_range(0, 4095));
        y = int'($urandom_range(0, 4095));
      end else begin
        x = m_x + int'($urandom_range(0, 40)) - 20;
        y = m_y + int'($urandom_range(0, 40)) - 20;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
      end
      apply(vb, v, x, y, j);
      chk_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rect_pos_ctl.md
RECT_POS_CTL -- requirements
Module: rect_pos_ctl

Interface
REQ-001 Parameter H_ACTIVE, default 800: visible screen width in pixels.
REQ-002 Parameter V_ACTIVE, default 600: visible screen height in lines.
REQ-003 Parameter RECT_WIDTH, default 48: width of the controlled rectangle.
REQ-004 Parameter RECT_HEIGHT, default 64: height of the controlled rectangle.
REQ-005 Parameter STEP, default 4: maximum glide displacement per axis per frame, range 1..255.
REQ-006 Parameters INIT_X and INIT_Y, default 0 each: position after reset.
REQ-007 Port clk, input, 1: single clock; all state is updated on the rising edge.
REQ-008 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-009 Port vblnk, input, 1: vertical blanking from the VGA timing chain.
REQ-010 Port req_valid, input, 1: a move request is present.
REQ-011 Port req_x, input, 12: requested x of the top-left corner.
REQ-012 Port req_y, input, 12: requested y of the top-left corner.
REQ-013 Port req_jump, input, 1: 1 = jump directly to the target, 0 = glide toward it.
REQ-014 Port req_ready, output, 1: a request is accepted on any clock edge where req_valid and req_ready are both 1.
REQ-015 Ports x_pos and y_pos, output, 12 each: registered position that drives the rectangle drawer.
REQ-016 Port busy, output, 1: the FSM is not in IDLE.
REQ-017 Port done, output, 1: one-cycle pulse when the position reaches the target.

Function
REQ-018 frame_start SHALL be vblnk AND NOT vblnk_d, where vblnk_d is vblnk registered once.
REQ-019 x_pos and y_pos SHALL change only on a clock edge where frame_start=1; the new value is visible from the next cycle, so it never changes during active video.
REQ-020 On acceptance the block SHALL latch:
- tgt_x = min(req_x, H_ACTIVE-RECT_WIDTH)
- tgt_y = min(req_y, V_ACTIVE-RECT_HEIGHT)
- mode = req_jump
REQ-021 The FSM SHALL have exactly three states: IDLE, ARMED and GLIDE.
REQ-022 req_ready SHALL be 1 in IDLE and GLIDE and 0 in ARMED; it is decoded combinationally from the state only.
REQ-023 In IDLE, an accepted request SHALL move the FSM to ARMED.
REQ-024 In ARMED, on frame_start with mode=1, the block SHALL set pos to tgt, pulse done and go to IDLE.
REQ-025 In ARMED, on frame_start with mode=0, the block SHALL apply one step; it goes to IDLE and pulses done if pos reaches tgt, otherwise to GLIDE.
REQ-026 In GLIDE, on each frame_start the block SHALL apply one step; on reaching tgt it pulses done and goes to IDLE.
REQ-027 A step SHALL be applied per axis independently:
- if |tgt-pos| <= STEP then pos = tgt
- otherwise pos moves by STEP toward tgt
- arithmetic is unsigned 12-bit, with no overshoot and no wrap-around.
REQ-028 In GLIDE, an accepted request SHALL replace tgt and mode and move the FSM to ARMED.
REQ-029 In GLIDE, if an accept and frame_start occur on the same edge, the accept SHALL win and the position SHALL be held for that frame.
REQ-030 A request whose clamped target equals the current pos SHALL still pass through ARMED and pulse done at the next frame_start.
REQ-031 done SHALL be asserted only on the cycle following the completing frame_start edge.

Reset
REQ-032 While rst_n=0, the block SHALL force, asynchronously:
- state=IDLE, x_pos=INIT_X, y_pos=INIT_Y
- tgt_x=INIT_X, tgt_y=INIT_Y, mode=0
- vblnk_d=1 (no spurious frame_start on reset exit), busy=0, done=0
REQ-033 A reset asserted mid-glide or mid-ARMED SHALL discard the pending target.

Verification
REQ-034 Jump: request (300,200,jump=1) in IDLE -> req_ready drops next cycle; x_pos/y_pos stay 0 until the vblnk rise, then read 300/200 with done=1 for one cycle and busy=0.
REQ-035 Glide: pos (0,0), STEP=4, request (10,3,jump=0) -> frame 1 gives (4,3), frame 2 gives (8,3), frame 3 gives (10,3) with done; that is 3 frame_starts and 1 done pulse.
REQ-036 Clamp: request (900,700) -> final pos is (752,536); request (0xFFF,0xFFF) gives the same result.
REQ-037 Retarget: mid-glide toward (100,0) at pos (40,0), new request (20,0) with the accept on the same edge as frame_start -> pos holds at 40, then moves 36, 32, ... down to 20.
REQ-038 Reset: assert rst_n=0 asynchronously in GLIDE -> outputs are immediately INIT_X/INIT_Y, busy=0, req_ready=1; release rst_n with vblnk=1 -> no position change until the next vblnk rise.
REQ-039 Handshake: req_valid held high in ARMED -> no acceptance until IDLE or GLIDE; exactly one accept per req_valid&&req_ready edge.
